// File: rtl/mac_ctrl_pkg.sv
// Shared types and sizing helpers for the MAC array sequencing controller.
package mac_ctrl_pkg;

  localparam int NUM_ROWS_DEF = 8;
  localparam int VEC_LEN_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FILL,
    COMPUTE,
    DONE
  } mac_ctrl_state_t;

  // The step counter must represent every value up to rows+len without wrapping.
  function automatic int cnt_w(input int rows, input int len);
    return $clog2(rows + len + 1);
  endfunction

endpackage

// File: rtl/mac_skew_gen.sv
// Systolic window decode: maps compute step k to per-row A reads, the B read,
// and the MAC enables that trail the reads by the FIFO read latency.
module mac_skew_gen
  import mac_ctrl_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int VEC_LEN  = VEC_LEN_DEF,
  parameter int CW       = cnt_w(NUM_ROWS, VEC_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic                kill,
  input  logic [CW-1:0]       k,
  output logic [NUM_ROWS-1:0] a_rden,
  output logic                b_rden,
  output logic [NUM_ROWS-1:0] mac_en
);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    a_rden = '0;
    b_rden = 1'b0;
    if (active) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (int'(k) >= r && int'(k) < r + VEC_LEN) a_rden[r] = 1'b1;
      end
      b_rden = (int'(k) < VEC_LEN);
    end
  end

  // NOTE: state is declared with an asynchronous active-low reset and updated
  // only with non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en <= '0;
    end else if (kill) begin
      mac_en <= '0;
    end else begin
      mac_en <= a_rden;
    end
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencing FSM for a row of MAC units computing y = A*b: clear, wait for
// full FIFOs, stream a skewed read window, then report completion.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int VEC_LEN  = VEC_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_ROWS-1:0] a_full,
  input  logic [NUM_ROWS-1:0] a_empty,
  input  logic                b_full,
  input  logic                b_empty,
  output logic [NUM_ROWS-1:0] a_rden,
  output logic                b_rden,
  output logic                mac_clr,
  output logic [NUM_ROWS-1:0] mac_en,
  output logic                busy,
  output logic                done,
  output logic                result_valid,
  output logic                err
);

  localparam int CW   = cnt_w(NUM_ROWS, VEC_LEN);
  localparam int LAST = NUM_ROWS + VEC_LEN - 1;

  mac_ctrl_state_t state;
  logic [CW-1:0]   k;
  logic            underflow;
  logic            kill;

  // Reads are only decoded in COMPUTE, so an empty flag elsewhere is harmless.
  assign underflow = (|(a_rden & a_empty)) | (b_rden & b_empty);
  assign kill      = ((state != IDLE) && abort) || underflow;

  mac_skew_gen #(
    .NUM_ROWS (NUM_ROWS),
    .VEC_LEN  (VEC_LEN),
    .CW       (CW)
  ) u_skew (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (state == COMPUTE),
    .kill   (kill),
    .k      (k),
    .a_rden (a_rden),
    .b_rden (b_rden),
    .mac_en (mac_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      mac_clr      <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      done    <= 1'b0;
      if (state != IDLE && abort) begin
        // Abort outranks underflow and completion: no flags change.
        state <= IDLE;
        busy  <= 1'b0;
        k     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= CLEAR;
              mac_clr      <= 1'b1;
              busy         <= 1'b1;
              result_valid <= 1'b0;
              err          <= 1'b0;
            end
          end
          CLEAR: state <= FILL;
          FILL: begin
            if (&a_full && b_full) begin
              state <= COMPUTE;
              k     <= '0;
            end
          end
          COMPUTE: begin
            if (underflow) begin
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
              k     <= '0;
            end else if (k == CW'(LAST)) begin
              state <= DONE;
              done  <= 1'b1;
              k     <= '0;
            end else begin
              k <= k + CW'(1);
            end
          end
          DONE: begin
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: a cycle-indexed model derives every
// output from the run's start, fill and kill times; stimulus is randomized.
module tb_mac_array_ctrl;
  import mac_ctrl_pkg::*;

  localparam int NR    = 8;
  localparam int VL    = 8;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [NR-1:0] a_full, a_empty;
  logic          b_full, b_empty;
  logic [NR-1:0] a_rden, mac_en;
  logic          b_rden, mac_clr, busy, done, result_valid, err;

  always #5 clk = ~clk;

  mac_array_ctrl #(.NUM_ROWS(NR), .VEC_LEN(VL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .a_full       (a_full),
    .a_empty      (a_empty),
    .b_full       (b_full),
    .b_empty      (b_empty),
    .a_rden       (a_rden),
    .b_rden       (b_rden),
    .mac_clr      (mac_clr),
    .mac_en       (mac_en),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .err          (err)
  );

  typedef struct packed {
    logic [NR-1:0] a_rden;
    logic          b_rden;
    logic          mac_clr;
    logic [NR-1:0] mac_en;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic          err;
  } obs_t;

  int   cyc, n_pass, n_checks;
  bit   run_valid, kill_err, err0, rv0, noisy, start_noise;
  int   run_s, fill_at, kill_at, uf_row, run_end;
  obs_t act, e;

  function automatic obs_t observe();
    return {a_rden, b_rden, mac_clr, mac_en, busy, done, result_valid, err};
  endfunction

  function automatic int comp_start();
    return ((run_s + 2 > fill_at) ? run_s + 2 : fill_at) + 1;
  endfunction

  // Expected outputs in cycle c, from the run's timeline alone.
  function automatic obs_t expect_at(input int c);
    obs_t x;
    int   cs, d, fin;
    x = '0;
    if (!run_valid || c <= run_s) begin
      x.err          = err0;
      x.result_valid = rv0;
      return x;
    end
    cs  = comp_start();
    d   = cs + NR + VL;
    fin = (kill_at < d) ? kill_at : d;
    x.busy    = (c <= fin);
    x.mac_clr = (c == run_s + 1);
    for (int r = 0; r < NR; r++) begin
      x.a_rden[r] = (c >= cs + r) && (c < cs + r + VL) && (c <= kill_at);
      x.mac_en[r] = (c - 1 >= cs + r) && (c - 1 < cs + r + VL) && (c - 1 < kill_at);
    end
    x.b_rden       = (c >= cs) && (c < cs + VL) && (c <= kill_at);
    x.done         = (c == d) && (kill_at >= d);
    x.result_valid = (c > d) && (kill_at > d);
    x.err          = kill_err && (c > kill_at);
    return x;
  endfunction

  // kill_off < 0: run completes; otherwise kill at run_s + kill_off.
  task automatic begin_run(input int fill_delay, input int kill_off, input bit k_err, input int row);
    obs_t p;
    int   d;
    p         = expect_at(cyc);
    err0      = p.err;
    rv0       = p.result_valid;
    run_valid = 1'b1;
    run_s     = cyc + 1;
    fill_at   = run_s + 2 + fill_delay;
    kill_err  = k_err;
    uf_row    = row;
    kill_at   = (kill_off < 0) ? NEVER : run_s + kill_off;
    d         = comp_start() + NR + VL;
    run_end   = ((kill_at < d) ? kill_at : d) + 3;
  endtask

  task automatic drive();
    obs_t x;
    x = expect_at(cyc);
    a_full = '1;
    b_full = 1'b1;
    if (run_valid && cyc < fill_at) begin
      if (noisy) begin
        a_full = NR'($urandom) & ~(NR'(1) << $urandom_range(0, NR - 1));
        b_full = 1'($urandom);
      end else begin
        b_full = 1'b0;
      end
    end
    a_empty = noisy ? (NR'($urandom) & ~x.a_rden) : '0;
    b_empty = noisy ? (1'($urandom) & ~x.b_rden) : 1'b0;
    if (run_valid && cyc == kill_at && kill_err) begin
      if (uf_row < NR) a_empty[uf_row] = 1'b1;
      else             b_empty = 1'b1;
    end
    start = run_valid && ((cyc == run_s) || (start_noise && x.busy && $urandom_range(0, 2) == 0));
    abort = (run_valid && cyc == kill_at && !kill_err) ||
            (noisy && !x.busy && !(run_valid && cyc == run_s) && $urandom_range(0, 3) == 0);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    a_full = '1; b_full = 1'b1; start = 1'b1; abort = 1'b0;
    #2;
    act = observe();
    n_checks++;
    if (act !== obs_t'('0)) $display("FAIL reset_hold got=%h want=0", act);
    else n_pass++;
    start = 1'b0;
    @(posedge clk);
    #1;
    act = observe();
    n_checks++;
    if (act !== obs_t'('0)) $display("FAIL reset_edge got=%h want=0", act);
    else n_pass++;
  endtask

  task automatic test_nominal();
    int done_cyc, first_a7;
    done_cyc = -1; first_a7 = -1;
    noisy = 1'b0; start_noise = 1'b0;
    begin_run(0, -1, 1'b0, 0);
    while (cyc <= run_end) begin
      drive();
      @(negedge clk);
      act = observe(); e = expect_at(cyc);
      n_checks++;
      if (act !== e) $display("FAIL nominal cyc=%0d got=%h want=%h", cyc - run_s, act, e);
      else n_pass++;
      if (act.done && done_cyc < 0) done_cyc = cyc;
      if (act.a_rden[NR-1] && first_a7 < 0) first_a7 = cyc;
      advance();
    end
    n_checks++;
    if (done_cyc !== run_s + 19) $display("FAIL nominal_done_cycle got=%0d want=19", done_cyc - run_s);
    else n_pass++;
    n_checks++;
    if (first_a7 !== run_s + 10) $display("FAIL nominal_a7_first got=%0d want=10", first_a7 - run_s);
    else n_pass++;
    n_checks++;
    if (result_valid !== 1'b1) $display("FAIL nominal_result_valid got=%b want=1", result_valid);
    else n_pass++;
  endtask

  task automatic test_slow_fill();
    int first_en, done_cyc;
    first_en = -1; done_cyc = -1;
    noisy = 1'b0; start_noise = 1'b0;
    begin_run(18, -1, 1'b0, 0);
    while (cyc <= run_end) begin
      drive();
      @(negedge clk);
      act = observe(); e = expect_at(cyc);
      n_checks++;
      if (act !== e) $display("FAIL slow_fill cyc=%0d got=%h want=%h", cyc - run_s, act, e);
      else n_pass++;
      if ((|act.a_rden || act.b_rden) && first_en < 0) first_en = cyc;
      if (act.done && done_cyc < 0) done_cyc = cyc;
      advance();
    end
    n_checks++;
    if (first_en !== run_s + 21) $display("FAIL slow_fill_first_read got=%0d want=21", first_en - run_s);
    else n_pass++;
    n_checks++;
    if (done_cyc !== run_s + 37) $display("FAIL slow_fill_done got=%0d want=37", done_cyc - run_s);
    else n_pass++;
  endtask

  task automatic test_underflow();
    bit saw_done;
    saw_done = 1'b0;
    noisy = 1'b0; start_noise = 1'b0;
    begin_run(0, 3 + 5, 1'b1, 5);
    while (cyc <= run_end) begin
      drive();
      @(negedge clk);
      act = observe(); e = expect_at(cyc);
      n_checks++;
      if (act !== e) $display("FAIL underflow cyc=%0d got=%h want=%h", cyc - run_s, act, e);
      else n_pass++;
      saw_done |= act.done;
      advance();
    end
    n_checks++;
    if (saw_done || err !== 1'b1 || busy !== 1'b0)
      $display("FAIL underflow_end got done=%b err=%b busy=%b want done=0 err=1 busy=0", saw_done, err, busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    noisy = 1'b0; start_noise = 1'b0;
    begin_run(0, 3 + 6, 1'b0, 0);
    while (cyc <= run_end) begin
      drive();
      @(negedge clk);
      act = observe(); e = expect_at(cyc);
      n_checks++;
      if (act !== e) $display("FAIL abort cyc=%0d got=%h want=%h", cyc - run_s, act, e);
      else n_pass++;
      if (cyc == kill_at + 1) begin
        n_checks++;
        if (act !== obs_t'('0)) $display("FAIL abort_next got=%h want=0", act);
        else n_pass++;
      end
      advance();
    end
    begin_run(0, -1, 1'b0, 0);
    while (cyc <= run_end) begin
      drive();
      @(negedge clk);
      act = observe(); e = expect_at(cyc);
      n_checks++;
      if (act !== e) $display("FAIL abort_rerun cyc=%0d got=%h want=%h", cyc - run_s, act, e);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_busy_start_and_reset();
    int rst_at;
    noisy = 1'b0; start_noise = 1'b1;
    begin_run(0, -1, 1'b0, 0);
    rst_at = run_s + 3 + 5;
    while (cyc <= rst_at) begin
      drive();
      @(negedge clk);
      act = observe(); e = expect_at(cyc);
      n_checks++;
      if (act !== e) $display("FAIL busy_start cyc=%0d got=%h want=%h", cyc - run_s, act, e);
      else n_pass++;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        act = observe();
        n_checks++;
        if (act !== obs_t'('0)) $display("FAIL reset_mid_run got=%h want=0", act);
        else n_pass++;
        run_valid = 1'b0; err0 = 1'b0; rv0 = 1'b0;
      end
      advance();
    end
    rst_n = 1'b1;
    start_noise = 1'b0;
    repeat (4) begin
      drive();
      @(negedge clk);
      act = observe(); e = expect_at(cyc);
      n_checks++;
      if (act !== e) $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, act, e);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_enable_count();
    int cnt [NR];
    int overlap;
    overlap = 0;
    foreach (cnt[r]) cnt[r] = 0;
    noisy = 1'b1; start_noise = 1'b1;
    begin_run($urandom_range(0, 5), -1, 1'b0, 0);
    while (cyc <= run_end) begin
      drive();
      @(negedge clk);
      act = observe(); e = expect_at(cyc);
      n_checks++;
      if (act !== e) $display("FAIL en_count_run cyc=%0d got=%h want=%h", cyc - run_s, act, e);
      else n_pass++;
      for (int r = 0; r < NR; r++) cnt[r] += int'(act.mac_en[r]);
      if (act.mac_clr && |act.mac_en) overlap++;
      advance();
    end
    for (int r = 0; r < NR; r++) begin
      n_checks++;
      if (cnt[r] !== VL) $display("FAIL en_count row=%0d got=%0d want=%0d", r, cnt[r], VL);
      else n_pass++;
    end
    n_checks++;
    if (overlap !== 0) $display("FAIL clr_en_overlap got=%0d want=0", overlap);
    else n_pass++;
  endtask

  task automatic test_random();
    int fd, kind, cs_off, d_off, row, koff;
    noisy = 1'b1; start_noise = 1'b1;
    repeat (12) begin
      fd     = $urandom_range(0, 5);
      kind   = $urandom_range(0, 2);
      cs_off = 3 + fd;
      d_off  = cs_off + NR + VL;
      row    = $urandom_range(0, NR);
      if (kind == 0) begin
        begin_run(fd, -1, 1'b0, 0);
      end else if (kind == 1) begin
        begin_run(fd, $urandom_range(1, d_off - 1), 1'b0, 0);
      end else begin
        koff = ((row < NR) ? row : 0) + $urandom_range(0, VL - 1);
        begin_run(fd, cs_off + koff, 1'b1, row);
      end
      while (cyc <= run_end) begin
        drive();
        @(negedge clk);
        act = observe(); e = expect_at(cyc);
        n_checks++;
        if (act !== e) $display("FAIL random kind=%0d cyc=%0d got=%h want=%h", kind, cyc - run_s, act, e);
        else n_pass++;
        advance();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    a_full = '0; a_empty = '0; b_full = 1'b0; b_empty = 1'b0;
    cyc = 0; n_pass = 0; n_checks = 0;
    run_valid = 1'b0; kill_err = 1'b0; err0 = 1'b0; rv0 = 1'b0;
    noisy = 1'b0; start_noise = 1'b0;
    run_s = 0; fill_at = 0; kill_at = NEVER; uf_row = 0; run_end = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_nominal();
    test_slow_fill();
    test_underflow();
    test_abort();
    test_busy_start_and_reset();
    test_enable_count();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
